// File: rtl/mux2_arbiter.sv
// Packet-aware round-robin 2:1 arbiter driving the shared-channel mux select; grant lands one edge after an IDLE request.
// Backpressure: i_ready=0 holds the granted beat on the channel with no ack; a granted requester owns the channel until its last beat transfers.
module mux2_arbiter #(
  parameter int DWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req0,
  input  logic [DWIDTH-1:0] i_data0,
  input  logic              i_last0,
  output logic              o_ack0,
  input  logic              i_req1,
  input  logic [DWIDTH-1:0] i_data1,
  input  logic              i_last1,
  output logic              o_ack1,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_sel,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   rr_ptr;
  logic   xfer;

  // Masked by reset so an abandoned packet never sees a final ack on the reset edge.
  assign o_valid = i_rstn & (((state == GNT0) & i_req0) | ((state == GNT1) & i_req1));
  assign o_data  = o_sel ? i_data1 : i_data0;
  assign o_last  = o_sel ? i_last1 : i_last0;
  assign xfer    = o_valid & i_ready;
  assign o_ack0  = xfer & ~o_sel;
  assign o_ack1  = xfer & o_sel;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state  <= IDLE;
      rr_ptr <= 1'b1;
      o_sel  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req0 && (!i_req1 || rr_ptr)) begin
            state <= GNT0;
            o_sel <= 1'b0;
          end else if (i_req1) begin
            state <= GNT1;
            o_sel <= 1'b1;
          end
        end
        GNT0: begin
          if (xfer && i_last0) begin
            rr_ptr <= 1'b0;
            if (i_req1) begin
              state <= GNT1;
              o_sel <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GNT1: begin
          if (xfer && i_last1) begin
            rr_ptr <= 1'b1;
            if (i_req0) begin
              state <= GNT0;
              o_sel <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed plus randomized bench for mux2_arbiter against a cycle-level ownership model.
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0, ready = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, valid, last, sel, busy;
  logic [7:0] data;

  int checks = 0;
  int failures = 0;

  // Model: who owns the channel (-1 = nobody), who was served last, current select.
  int owner = -1;
  int last_served = 1;
  int exp_sel = 0;

  always #5 clk = ~clk;

  mux2_arbiter #(.DWIDTH(8)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0(req0), .i_data0(data0), .i_last0(last0), .o_ack0(ack0),
    .i_req1(req1), .i_data1(data1), .i_last1(last1), .o_ack1(ack1),
    .o_valid(valid), .o_data(data), .o_last(last), .i_ready(ready),
    .o_sel(sel), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model over the edge.
  task automatic cyc(input bit rs, input bit r0, input logic [7:0] d0, input bit l0,
                     input bit r1, input logic [7:0] d1, input bit l1, input bit rdy);
    int  ev, eack0, eack1, g, other;
    bit  reqs [2];
    bit  lasts [2];
    @(negedge clk);
    rstn = rs; req0 = r0; data0 = d0; last0 = l0;
    req1 = r1; data1 = d1; last1 = l1; ready = rdy;
    #1;
    reqs[0] = r0; reqs[1] = r1; lasts[0] = l0; lasts[1] = l1;
    ev = (rs && owner >= 0 && reqs[owner]) ? 1 : 0;
    eack0 = (ev == 1 && rdy && owner == 0) ? 1 : 0;
    eack1 = (ev == 1 && rdy && owner == 1) ? 1 : 0;
    chk("valid", valid, ev);
    chk("ack0", ack0, eack0);
    chk("ack1", ack1, eack1);
    chk("busy", busy, (owner >= 0) ? 1 : 0);
    chk("sel", sel, exp_sel);
    if (ev == 1) begin
      chk("data", data, (owner == 1) ? d1 : d0);
      chk("last", last, (owner == 1) ? l1 : l0);
    end
    if (!rs) begin
      owner = -1; last_served = 1; exp_sel = 0;
    end else if (owner < 0) begin
      g = -1;
      if (r0 && r1) g = 1 - last_served;
      else if (r0) g = 0;
      else if (r1) g = 1;
      if (g >= 0) begin owner = g; exp_sel = g; end
    end else if (ev == 1 && rdy && lasts[owner]) begin
      last_served = owner;
      other = 1 - owner;
      if (reqs[other]) begin owner = other; exp_sel = other; end
      else owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Prelude edge so the DUT state is defined before any comparison.
    @(posedge clk);
    #1;

    // Reset held with both requesters active, then release.
    cyc(0, 1, 8'h5A, 0, 1, 8'h66, 0, 0);
    cyc(0, 1, 8'h5A, 0, 1, 8'h66, 0, 0);
    cyc(1, 1, 8'h5A, 0, 1, 8'h66, 0, 0);
    chk("rel_valid", valid, 1);
    chk("rel_data", data, 8'h5A);
    chk("rel_sel", sel, 0);
    cyc(1, 1, 8'h5A, 1, 1, 8'h66, 0, 1);

    // Single requester 1, three-beat packet.
    cyc(1, 0, 8'h00, 0, 1, 8'h11, 0, 1);
    cyc(1, 0, 8'h00, 0, 1, 8'h22, 0, 1);
    cyc(1, 0, 8'h00, 0, 1, 8'h33, 1, 1);
    cyc(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    chk("single_idle_busy", busy, 0);

    // Round-robin: both continuously requesting two-beat packets.
    for (int i = 0; i < 10; i++)
      cyc(1, 1, 8'(8'h40 + i), (i > 0 && i % 2 == 0), 1, 8'(8'h80 + i), (i > 0 && i % 2 == 0), 1);

    // Backpressure on a granted requester 0.
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(1, 1, 8'hA5, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'hA5, 1, 0, 8'h00, 0, 0);
    cyc(1, 1, 8'hA5, 1, 0, 8'h00, 0, 1);

    // Requester 0 drops mid-packet while requester 1 waits.
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(1, 1, 8'h01, 0, 0, 8'h00, 0, 1);
    cyc(1, 1, 8'h01, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00, 0, 1, 8'hEE, 0, 1);
    cyc(1, 1, 8'h02, 1, 1, 8'hEE, 0, 1);
    chk("drop_sel", sel, 1);

    // Reset mid-packet while requester 1 owns the channel.
    cyc(1, 0, 8'h00, 0, 1, 8'h10, 0, 1);
    cyc(0, 1, 8'h07, 0, 1, 8'h20, 0, 1);
    cyc(1, 1, 8'h07, 0, 1, 8'h20, 0, 1);
    chk("rst_mid_sel", sel, 0);
    chk("rst_mid_valid", valid, 1);
    chk("rst_mid_data", data, 8'h07);

    // Randomized traffic, including rare resets.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Shares one output channel between two requesters using a registered-grant 2:1 select.
- Packet-aware round-robin arbitration: once granted, a requester keeps the channel until its last beat is accepted.
- Sits in front of the 2:1 datapath mux and drives its select. Consumers use valid/ready on the shared side.

Parameters:
- DWIDTH, 8, data width of each requester and of the shared output.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  synchronous active-low reset, sampled on the rising edge of i_clk.
- i_req0  input  1  requester 0 has a valid beat.
- i_data0  input  DWIDTH  requester 0 beat data.
- i_last0  input  1  requester 0 beat is the last of its packet.
- o_ack0  output  1  requester 0 beat accepted this cycle.
- i_req1  input  1  requester 1 has a valid beat.
- i_data1  input  DWIDTH  requester 1 beat data.
- i_last1  input  1  requester 1 beat is the last of its packet.
- o_ack1  output  1  requester 1 beat accepted this cycle.
- o_valid  output  1  shared channel beat valid.
- o_data  output  DWIDTH  shared channel data.
- o_last  output  1  shared channel last flag.
- i_ready  input  1  downstream accepts the beat when o_valid is high.
- o_sel  output  1  current grant / mux select: 0 = requester 0, 1 = requester 1.
- o_busy  output  1  a packet is in progress (state is not IDLE).

Behaviour:
State machine and registers:
- States: IDLE, GNT0, GNT1.
- rr_ptr register holds the requester served last.
- Reset (i_rstn=0 at a clock edge): state=IDLE, rr_ptr=1 so requester 0 wins the first tie, o_sel=0.
- Reset values of outputs: o_valid=0, o_ack0=0, o_ack1=0, o_busy=0. o_data and o_last follow requester 0 through the mux (don't-care while o_valid=0).

Datapath and handshake:
- Datapath is combinational through the mux selected by o_sel.
- o_data = o_sel ? i_data1 : i_data0. o_last = o_sel ? i_last1 : i_last0.
- o_valid = (state==GNT0 & i_req0) | (state==GNT1 & i_req1). o_valid is always 0 in IDLE.
- Transfer occurs when o_valid & i_ready.
- o_ackN = transfer & (o_sel==N). o_ackN is never high for a non-granted requester.

IDLE transitions:
- No request: stay in IDLE.
- Only req0 high: go to GNT0. Only req1 high: go to GNT1.
- Both high: grant the requester != rr_ptr.
- Grant latency: a request first seen in IDLE produces o_valid on the next cycle. o_sel is updated in the same edge as the state.

GNTn transitions:
- Hold while there is no transfer, or there is a transfer with last=0.
- On a transfer with last=1: set rr_ptr=n.
  - If the other requester's req is high in that same cycle, go directly to GNT(other) with no bubble.
  - Else if req n is high, go back to IDLE. Requester n then re-arbitrates next cycle; a 1-cycle bubble is allowed.
  - Else go to IDLE.
- If i_reqn drops while granted: o_valid=0 (stall) and the grant is held. A requester must not lose the channel mid-packet.
- The other requester's req and data never affect the outputs while not granted.

Boundary conditions:
- Single-beat packets (req and last high together) behave as a normal last beat.
- Continuous back-to-back packets from both requesters strictly alternate.
- i_ready=0 while o_valid=1: no ack; o_data and o_last track the granted requester's inputs.
- Reset asserted mid-packet: returns to IDLE next edge. The packet is abandoned with no ack that cycle.

Test Plan:
- Reset: hold i_rstn=0 for 2 cycles with both reqs high -> o_valid=0, o_ack0=0, o_ack1=0, o_busy=0, o_sel=0. Release -> GNT0 after 1 edge, o_valid=1, o_data=i_data0.
- Single requester: req1=1 with 3-beat packet 0x11, 0x22, 0x33 (last on 0x33), i_ready=1 -> o_sel=1, three o_ack1 pulses, o_data sequence 0x11, 0x22, 0x33, then IDLE.
- Round-robin: both reqs continuously high, 2-beat packets each -> grants alternate 0,1,0,1. The switch happens on the cycle after the last beat with no bubble; o_ack0 and o_ack1 are never high together.
- Backpressure: granted req0 with data 0xA5, i_ready=0 for 4 cycles -> o_valid=1, o_data=0xA5, o_ack0=0 all 4 cycles. Set i_ready=1 -> single o_ack0.
- Mid-packet drop: req0 granted, first beat (last=0) accepted, req0 low for 3 cycles while req1=1 -> o_valid=0, o_sel stays 0, o_ack1=0. Req0 returns with last=1 -> accepted, then grant moves to GNT1.
- Reset mid-packet: in GNT1 after 1 of 3 beats, pulse i_rstn=0 for one edge -> next cycle state=IDLE, o_busy=0, rr_ptr=1. With both reqs high, requester 0 is granted next.
